aer_tx: RTL

Address-Event Representation transmitter for the output side of the neuromorphic core. It accepts spike events from the core over a valid/ready interface and buffers them in a small FIFO. It drains each event onto the off-chip AER bus with a 4-phase bundled-data REQ/ACK handshake. ACK comes from an asynchronous receiver and is synchronized internally.

---
 rtl/aer_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/aer_tx.sv
// aer_tx: Address-Event Representation transmitter.
// Spike events from the core are buffered in a small FIFO. Each event is
// then sent on the off-chip AER bus with a 4-phase bundled-data REQ/ACK
// handshake. The asynchronous ACK passes through a flop synchronizer.
//
// Core side handshake: an event transfers on a rising CLK edge where
// EVT_VALID and EVT_READY are both high. EVT_VALID must hold EVT_ADDR
// stable until that edge. EVT_READY depends only on the registered
// FIFO level, never on EVT_VALID.
module aer_tx #(
    parameter int ADDR_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EVT_VALID,
    input  logic [ADDR_W-1:0]             EVT_ADDR,
    output logic                          EVT_READY,
    output logic                          AEROUT_REQ,
    output logic [ADDR_W-1:0]             AEROUT_ADDR,
    input  logic                          AEROUT_ACK,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          BUSY,
    output logic [1:0]                    DBG_STATE
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_REQ_HI = 2'd2,
        S_ACK_LO = 2'd3
    } state_t;

    logic [ADDR_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [LVL_W-1:0]       r_level;
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic                   r_req;
    logic [ADDR_W-1:0]      r_addr;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_ack_s;
    logic w_ack_clear;

    assign w_ready = (r_level != FULL_LVL);
    assign w_push  = EVT_VALID && w_ready;
    assign w_ack_s = r_sync[SYNC_STAGES-1];
    // A new request starts only when every synchronizer stage has seen ACK
    // low. Otherwise an ACK still held high across reset release would go
    // unnoticed while the reset zeros drain out of the chain.
    assign w_ack_clear = (r_sync == '0);
    assign w_pop = (r_state == S_IDLE) && (r_level != '0) && w_ack_clear;

    // Synchronize the asynchronous acknowledge into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], AEROUT_ACK};
        end
    end

    // FIFO storage write; contents need no reset because level gates reads.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= EVT_ADDR;
        end
    end

    // FIFO pointers and occupancy counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // 4-phase handshake FSM. The address is loaded only when an event is
    // popped, so it stays frozen through REQ high and the ACK-low wait.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_req <= 1'b0;
                    if (w_pop) begin
                        r_addr  <= r_mem[r_rptr];
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_req   <= 1'b1;
                    r_state <= S_REQ_HI;
                end
                S_REQ_HI: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= S_ACK_LO;
                    end
                end
                S_ACK_LO: begin
                    r_req <= 1'b0;
                    if (!w_ack_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign EVT_READY   = w_ready;
    assign AEROUT_REQ  = r_req;
    assign AEROUT_ADDR = r_addr;
    assign FIFO_LEVEL  = r_level;
    assign BUSY        = (r_level != '0) || (r_state != S_IDLE);
    assign DBG_STATE   = r_state;

endmodule
